remote_comm: RTL and testbench
==============================

Name: remote_comm

Overview:
- Host-side UART command link used by the system-level bench to drive the knight-tour robot.
- Accepts a 16-bit command and serialises it as two 8N1 UART bytes, high byte first, onto TX.
- Receives single-byte responses on RX and presents each one with a ready strobe.
- Pairs with the robot's command UART; RX and TX cross-connect to the robot's TX and RX.

Parameters:
BAUD_DIV, 2604, clocks per UART bit (19200 baud at 50 MHz); must be >= 16.

Ports:
clk       input   1   system clock, all logic on rising edge
rst       input   1   asynchronous reset, active-high
RX        input   1   serial response line from robot; idle high; asynchronous
TX        output  1   serial command line to robot; idle high
cmd       input   16  command word; sampled only on the snd_cmd cycle
snd_cmd   input   1   one-cycle start request
cmd_snt   output  1   level; set when both bytes are fully transmitted, cleared on next accepted snd_cmd
resp_rdy  output  1   one-cycle pulse when a response byte has been received
resp      output  8   last received response byte; held until the next byte arrives

Behaviour:
Reset values:
- TX=1, cmd_snt=0, resp_rdy=0, resp=8'h00.
- Sender FSM in IDLE; receiver idle.
- Asserting rst mid-frame aborts at once; TX returns high asynchronously.

Sender FSM: IDLE -> SEND_HI -> SEND_LO -> IDLE.
- IDLE, snd_cmd=1:
  - latch cmd[7:0] into an internal low-byte register;
  - load cmd[15:8] into the transmitter and start it;
  - clear cmd_snt; go to SEND_HI.
- SEND_HI, tx_done: load the low byte, start the transmitter; go to SEND_LO.
- SEND_LO, tx_done: set cmd_snt; go to IDLE.
- snd_cmd outside IDLE is ignored; the in-flight command is unaffected.
- cmd changes after the snd_cmd cycle have no effect.

Transmitter (8N1, LSB first):
- Frame is start bit 0, data[0..7], stop bit 1; each bit lasts exactly BAUD_DIV clocks.
- TX changes on the clock edge after the start request.
- tx_done pulses one cycle at the end of the stop bit.
- A full command takes 20*BAUD_DIV clocks; cmd_snt rises about 20*BAUD_DIV+2 clocks after snd_cmd.

Receiver:
- RX passes through a two-flop synchroniser, preset to 1 on reset.
- In idle, a falling edge (synchronised RX = 0) starts a frame.
- First sample is taken BAUD_DIV/2 clocks after the edge (mid start bit), then every BAUD_DIV clocks.
- The start sample is not re-checked for validity.
- Eight data bits are shifted in LSB first.
- At mid stop bit: resp <= shifted byte, resp_rdy pulses one cycle, receiver returns to idle.
- A stop-bit value of 0 is still accepted; there is no framing-error output.
- Receive and transmit run fully independently and may overlap.

Protocol facts (for users and bench):
- Command opcode is cmd[15:12]: 4'h2 = calibrate gyro, 4'h4 = move, 4'h5 = move with fanfare, 4'h6 = tour.
- For moves, cmd[11:4] = heading (8'h00 north, 8'h3F west, 8'h7F south, 8'hBF east) and cmd[3:0] = squares.
- Robot replies 8'hA5 (positive acknowledge) after calibration completes and after each move completes.
- This block does not interpret opcodes or response values.

Decomposition:
- Shared package knight_pkg holds:
  - opcode constants;
  - heading constants NORTH/WEST/SOUTH/EAST;
  - POS_ACK = 8'hA5;
  - the sender FSM state enum.
- Sub-module uart_link (tx + rx, BAUD_DIV parameter, ports trmt/tx_data/tx_done/rx_rdy/rx_data).
- remote_comm holds the two-byte sender FSM and the cmd_snt/resp registers around uart_link.

Test Plan:
- Reset: hold rst, release. Require TX=1, cmd_snt=0, resp_rdy=0, resp=00 for 10*BAUD_DIV clocks.
- Send 16'h2000:
  - TX carries byte 8'h20, then byte 8'h00, each framed start/LSB-first/stop at BAUD_DIV spacing;
  - cmd_snt rises after 20*BAUD_DIV (+/-2) clocks and stays high.
- Send 16'h43F1 with snd_cmd re-pulsed and cmd changed to 16'hFFFF during SEND_HI:
  - TX carries only 8'h43 then 8'hF1;
  - the second request is ignored; no third byte is sent.
- Drive an 8N1 frame of 8'hA5 on RX at BAUD_DIV:
  - exactly one resp_rdy pulse, about 9.5*BAUD_DIV clocks after the start edge;
  - resp=8'hA5, held until the next frame.
- Full duplex: send 16'h6000 while RX simultaneously receives 8'h5A. TX bytes must be correct, resp=8'h5A, and cmd_snt must set.
- Assert rst during the 4th data bit of the high byte:
  - TX goes high immediately and cmd_snt stays 0;
  - after release, a new snd_cmd with 16'h4BF2 transmits 8'h4B, 8'hF2 correctly.

Source files
------------

// File: rtl/knight_pkg.sv
// knight_pkg: command opcodes, headings, response codes and sender states shared by the host link.
package knight_pkg;
    localparam logic [3:0] OP_CAL     = 4'h2;
    localparam logic [3:0] OP_MOVE    = 4'h4;
    localparam logic [3:0] OP_MOVE_FF = 4'h5;
    localparam logic [3:0] OP_TOUR    = 4'h6;
    localparam logic [7:0] NORTH      = 8'h00;
    localparam logic [7:0] WEST       = 8'h3F;
    localparam logic [7:0] SOUTH      = 8'h7F;
    localparam logic [7:0] EAST       = 8'hBF;
    localparam logic [7:0] POS_ACK    = 8'hA5;
    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} send_state_e;
endpackage

// File: rtl/uart_link.sv
// uart_link: independent 8N1 transmitter and receiver sharing one BAUD_DIV bit period.
module uart_link #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic       TX,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       rx_rdy,
    output logic [7:0] rx_data
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_END = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF    = CW'(BAUD_DIV / 2 - 1);

    logic          tx_busy_q, tx_busy_d, tx_end;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [9:0]    tx_sh_q, tx_sh_d;
    logic [1:0]    rx_sync_q;
    logic          rx_s, rx_start, rx_tick, rx_last;
    logic          rx_busy_q, rx_busy_d, rx_rdy_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;

    // A new request wins over the final stop-bit tick so back-to-back frames leave no idle gap.
    always_comb begin
        tx_end    = tx_busy_q && tx_cnt_q == BIT_END;
        tx_done   = tx_end && tx_bit_q == 4'd9;
        tx_busy_d = trmt | (tx_busy_q & ~tx_done);
        tx_cnt_d  = (trmt || tx_end) ? '0 : tx_cnt_q + CW'(tx_busy_q);
        tx_bit_d  = trmt ? 4'd0 : tx_end ? tx_bit_q + 4'd1 : tx_bit_q;
        tx_sh_d   = trmt ? {1'b1, tx_data, 1'b0} : tx_end ? {1'b1, tx_sh_q[9:1]} : tx_sh_q;
    end

    assign TX = ~tx_busy_q | tx_sh_q[0];

    // Bit 0 is the start sample and bit 9 the stop sample; only bits 1..8 carry data.
    always_comb begin
        rx_s      = rx_sync_q[1];
        rx_start  = ~rx_busy_q & ~rx_s;
        rx_tick   = rx_busy_q && rx_cnt_q == '0;
        rx_last   = rx_tick && rx_bit_q == 4'd9;
        rx_busy_d = rx_start | (rx_busy_q & ~rx_last);
        rx_cnt_d  = rx_start ? HALF : rx_tick ? BIT_END : rx_cnt_q - CW'(rx_busy_q);
        rx_bit_d  = rx_start ? 4'd0 : rx_tick ? rx_bit_q + 4'd1 : rx_bit_q;
        rx_sh_d   = (rx_tick && rx_bit_q != 4'd0 && rx_bit_q != 4'd9) ? {rx_s, rx_sh_q[7:1]} : rx_sh_q;
        rx_data_d = rx_last ? rx_sh_q : rx_data_q;
    end

    assign rx_rdy  = rx_rdy_q;
    assign rx_data = rx_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '1;
            rx_sync_q <= 2'b11;
            rx_busy_q <= 1'b0;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_rdy_q  <= 1'b0;
            rx_data_q <= '0;
        end else begin
            tx_busy_q <= tx_busy_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            rx_sync_q <= {rx_sync_q[0], RX};
            rx_busy_q <= rx_busy_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_rdy_q  <= rx_last;
            rx_data_q <= rx_data_d;
        end
    end
endmodule

// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command as two UART bytes (high first) and captures response bytes.
module remote_comm
    import knight_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        resp_rdy,
    output logic [7:0]  resp
);
    send_state_e state_q, state_d;
    logic       trmt, tx_done, rx_rdy, accept;
    logic [7:0] tx_data, rx_data, lo_q, lo_d, resp_q, resp_d;
    logic       cmd_snt_q, cmd_snt_d, resp_rdy_q;

    uart_link #(.BAUD_DIV(BAUD_DIV)) u_link (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
        .rx_rdy(rx_rdy), .rx_data(rx_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lo_q       <= '0;
            cmd_snt_q  <= 1'b0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            cmd_snt_q  <= cmd_snt_d;
            resp_q     <= resp_d;
            resp_rdy_q <= rx_rdy;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE && snd_cmd)    ? SEND_HI :
                  (state_q == SEND_HI && tx_done) ? SEND_LO :
                  (state_q == SEND_LO && tx_done) ? IDLE : state_q;
    end

    always_comb begin
        accept    = state_q == IDLE && snd_cmd;
        trmt      = accept || (state_q == SEND_HI && tx_done);
        tx_data   = state_q == IDLE ? cmd[15:8] : lo_q;
        lo_d      = accept ? cmd[7:0] : lo_q;
        cmd_snt_d = (state_q == SEND_LO && tx_done) | (cmd_snt_q & ~accept);
        resp_d    = rx_rdy ? rx_data : resp_q;
    end

    assign cmd_snt  = cmd_snt_q;
    assign resp_rdy = resp_rdy_q;
    assign resp     = resp_q;
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: directed checks of command framing, response capture, duplex and mid-frame reset.
module tb_remote_comm;
    import knight_pkg::*;
    localparam int B = 16;

    logic        clk = 1'b0, rst = 1'b1, RX = 1'b1, snd_cmd = 1'b0;
    logic [15:0] cmd = '0;
    logic        TX, cmd_snt, resp_rdy;
    logic [7:0]  resp;
    int          checks = 0, errors = 0, cyc = 0, t0 = 0, t_rx = 0;

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .snd_cmd(snd_cmd),
        .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] c);
        @(negedge clk);
        cmd = c;
        snd_cmd = 1'b1;
        t0 = cyc;
        @(negedge clk);
        snd_cmd = 1'b0;
    endtask

    // Waits for a start bit, then samples the middle of each of the ten bit periods.
    task automatic get_frame(output logic [9:0] f);
        int n = 0;
        f = 'x;
        while (TX !== 1'b0 && n < 25 * B) begin
            @(negedge clk);
            n++;
        end
        if (TX !== 1'b0) return;
        repeat (B / 2) @(negedge clk);
        f[0] = TX;
        for (int i = 1; i < 10; i++) begin
            repeat (B) @(negedge clk);
            f[i] = TX;
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] b);
        logic [9:0] f;
        get_frame(f);
        check(tag, {6'd0, f}, {6'd0, 1'b1, b, 1'b0});
    endtask

    task automatic drive_rx(input logic [7:0] b);
        @(negedge clk);
        RX = 1'b0;
        t_rx = cyc;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    task automatic quiet_tx(input string tag, input int n);
        int low = 0;
        repeat (n) begin
            @(negedge clk);
            if (TX !== 1'b1) low++;
        end
        check(tag, 16'(low), 16'd0);
    endtask

    initial begin
        int bad, d, n, lat;
        repeat (3) @(negedge clk);
        check("rst_tx", {15'd0, TX}, 16'd1);
        check("rst_snt", {15'd0, cmd_snt}, 16'd0);
        rst = 1'b0;
        bad = 0;
        repeat (10 * B) begin
            @(negedge clk);
            if (TX !== 1'b1 || cmd_snt !== 1'b0 || resp_rdy !== 1'b0 || resp !== 8'h00) bad++;
        end
        check("rst_hold", 16'(bad), 16'd0);
        check("rst_resp", {8'd0, resp}, 16'h0000);

        send({OP_CAL, 12'h000});
        expect_byte("cal_hi", 8'h20);
        check("cal_snt_mid", {15'd0, cmd_snt}, 16'd0);
        expect_byte("cal_lo", 8'h00);
        n = 0;
        while (cmd_snt !== 1'b1 && n < 4 * B) begin
            @(negedge clk);
            n++;
        end
        d = cyc - t0;
        check("cal_snt_lat", 16'(d >= 20 * B - 2 && d <= 20 * B + 3), 16'd1);
        quiet_tx("cal_no_extra", 3 * B);
        check("cal_snt_hold", {15'd0, cmd_snt}, 16'd1);

        fork
            begin
                send({OP_MOVE, WEST, 4'h1});
                check("mv_snt_clr", {15'd0, cmd_snt}, 16'd0);
                expect_byte("mv_hi", 8'h43);
                expect_byte("mv_lo", 8'hF1);
            end
            begin
                repeat (3 * B) @(negedge clk);
                cmd = 16'hFFFF;
                snd_cmd = 1'b1;
                @(negedge clk);
                snd_cmd = 1'b0;
            end
        join
        quiet_tx("mv_no_third", 12 * B);
        check("mv_snt", {15'd0, cmd_snt}, 16'd1);

        n = 0;
        lat = 0;
        fork
            drive_rx(POS_ACK);
            repeat (12 * B) begin
                @(negedge clk);
                if (resp_rdy === 1'b1) begin
                    n++;
                    if (n == 1) lat = cyc - t_rx;
                end
            end
        join
        check("ack_pulses", 16'(n), 16'd1);
        check("ack_lat", 16'(lat >= 19 * B / 2 && lat <= 19 * B / 2 + 8), 16'd1);
        check("ack_resp", {8'd0, resp}, 16'h00A5);
        repeat (2 * B) @(negedge clk);
        check("ack_held", {8'd0, resp}, 16'h00A5);

        fork
            begin
                send({OP_TOUR, 12'h000});
                expect_byte("dup_hi", 8'h60);
                expect_byte("dup_lo", 8'h00);
            end
            drive_rx(8'h5A);
        join
        repeat (2 * B) @(negedge clk);
        check("dup_resp", {8'd0, resp}, 16'h005A);
        check("dup_snt", {15'd0, cmd_snt}, 16'd1);

        send({OP_MOVE, NORTH, 4'h0});
        repeat (4 * B + B / 2 - 1) @(negedge clk);
        check("rst_mid_pre", {15'd0, TX}, 16'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", {15'd0, TX}, 16'd1);
        check("rst_mid_snt", {15'd0, cmd_snt}, 16'd0);
        check("rst_mid_resp", {8'd0, resp}, 16'h0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        quiet_tx("rst_mid_quiet", 12 * B);
        check("rst_mid_snt2", {15'd0, cmd_snt}, 16'd0);
        send({OP_MOVE, EAST, 4'h2});
        expect_byte("east_hi", 8'h4B);
        expect_byte("east_lo", 8'hF2);
        repeat (2 * B) @(negedge clk);
        check("east_snt", {15'd0, cmd_snt}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
